// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and helpers for the L1 I-cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        REQ   = 3'd2,
        FILL  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int c_word_off = 2;

    // Line address (tag+set) shifted up past the word and byte offsets.
    function automatic logic [63:0] line_addr(input logic [63:0] block_addr,
                                              input int          beat_bits);
        return block_addr << (beat_bits + c_word_off);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : icache_victim_sel
// Description : Victim way choice: lowest invalid way, else round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_victim_sel #(
    parameter int E     = 4,
    parameter int PTR_W = (E > 1) ? $clog2(E) : 1
) (
    input  logic [E-1:0]     ValidWays,
    input  logic [PTR_W-1:0] RrPtr,
    output logic [E-1:0]     Way
);

    logic w_found;

    always_comb begin
        Way     = '0;
        w_found = 1'b0;
        for (int i = 0; i < E; i++) begin
            if (!ValidWays[i] && !w_found) begin
                Way[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
        if (!w_found) begin
            Way = E'(1) << RrPtr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctlr.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctlr
// Description : E-way set-associative I-cache miss handler with B-beat refill.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctlr
    import icache_pkg::*;
#(
    parameter int S      = 64,
    parameter int E      = 4,
    parameter int B      = 4,
    parameter int ADDR_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(S)-1:0]          Set,
    input  logic [ADDR_W-$clog2(B)-3:0]   BlockAddr,
    input  logic                          LookupValid,
    input  logic [E-1:0]                  HitWay,
    input  logic [E-1:0]                  ValidWays,
    input  logic                          BranchPendingE,
    input  logic                          Redirect,
    input  logic                          MemAck,
    input  logic                          MemValid,
    output logic                          MemReq,
    output logic [ADDR_W-1:0]             MemAddr,
    output logic [S-1:0]                  ActiveArray,
    output logic                          InstrMissF,
    output logic                          InstrCacheRepActive,
    output logic                          RefillWE,
    output logic [E-1:0]                  RefillWay,
    output logic [$clog2(B)-1:0]          RefillWordIdx,
    output logic                          ValidClr,
    output logic                          TagWE
);

    localparam int c_set_w  = $clog2(S);
    localparam int c_beat_w = $clog2(B);
    localparam int c_ptr_w  = (E > 1) ? $clog2(E) : 1;
    localparam int c_ba_w   = ADDR_W - c_beat_w - c_word_off;

    state_t               r_state;
    state_t               w_next;
    logic [c_set_w-1:0]   r_set;
    logic [c_ba_w-1:0]    r_block_addr;
    logic [E-1:0]         r_way;
    logic [c_beat_w-1:0]  r_cnt;
    logic [c_ptr_w-1:0]   r_rr_ptr [S];
    logic [E-1:0]         w_victim;
    logic                 w_latch;
    logic                 w_last;
    logic                 w_beat;

    icache_victim_sel #(
        .E     (E),
        .PTR_W (c_ptr_w)
    ) u_victim_sel (
        .ValidWays (ValidWays),
        .RrPtr     (r_rr_ptr[Set]),
        .Way       (w_victim)
    );

    assign InstrMissF          = LookupValid & ~|HitWay;
    assign ActiveArray         = S'(1) << Set;
    assign InstrCacheRepActive = (r_state != IDLE) | (InstrMissF & ~Redirect);
    assign MemAddr             = ADDR_W'(line_addr(64'(r_block_addr), c_beat_w));
    assign RefillWay           = r_way;
    assign RefillWordIdx       = r_cnt;
    assign w_last              = (r_cnt == c_beat_w'(B - 1));
    assign w_beat              = MemValid & ((r_state == FILL) | (r_state == DRAIN));
    assign ValidClr            = RefillWE & (r_cnt == '0);
    assign TagWE               = RefillWE & w_last;

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        MemReq   = 1'b0;
        RefillWE = 1'b0;
        case (r_state)
            IDLE: begin
                if (InstrMissF && !Redirect) begin
                    if (BranchPendingE) begin
                        w_next = DELAY;
                    end else begin
                        w_next  = REQ;
                        w_latch = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (Redirect) begin
                    w_next = IDLE;
                end else begin
                    w_next  = REQ;
                    w_latch = 1'b1;
                end
            end
            REQ: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    w_next = Redirect ? DRAIN : FILL;
                end else if (Redirect) begin
                    w_next = IDLE;
                end
            end
            FILL: begin
                // A redirect landing on the final beat still commits the line.
                if (Redirect && !(MemValid && w_last)) begin
                    w_next = DRAIN;
                end else if (MemValid) begin
                    RefillWE = 1'b1;
                    if (w_last) begin
                        w_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (MemValid && w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_set        <= '0;
            r_block_addr <= '0;
            r_way        <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_set        <= Set;
                r_block_addr <= BlockAddr;
                r_way        <= w_victim;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Pointer only moves when the round-robin choice was actually consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < S; i++) begin
                r_rr_ptr[i] <= '0;
            end
        end else if (TagWE && (E > 1) && (r_way == (E'(1) << r_rr_ptr[r_set]))) begin
            r_rr_ptr[r_set] <= r_rr_ptr[r_set] + 1'b1;
        end
    end

    a_hitway_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(HitWay));

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctlr.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctlr
// Description : Self-checking bench: vector table, directed refills, random fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctlr;

    localparam int S   = 64;
    localparam int E   = 4;
    localparam int B   = 4;
    localparam int AW  = 32;
    localparam int BAW = AW - 2 - 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [5:0]     Set;
    logic [BAW-1:0] BlockAddr;
    logic           LookupValid, BranchPendingE, Redirect, MemAck, MemValid;
    logic [E-1:0]   HitWay, ValidWays;
    logic           MemReq, InstrMissF, InstrCacheRepActive, RefillWE, ValidClr, TagWE;
    logic [AW-1:0]  MemAddr;
    logic [S-1:0]   ActiveArray;
    logic [E-1:0]   RefillWay;
    logic [1:0]     RefillWordIdx;

    icache_refill_ctlr #(.S(S), .E(E), .B(B), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .Set(Set), .BlockAddr(BlockAddr),
        .LookupValid(LookupValid), .HitWay(HitWay), .ValidWays(ValidWays),
        .BranchPendingE(BranchPendingE), .Redirect(Redirect), .MemAck(MemAck),
        .MemValid(MemValid), .MemReq(MemReq), .MemAddr(MemAddr),
        .ActiveArray(ActiveArray), .InstrMissF(InstrMissF),
        .InstrCacheRepActive(InstrCacheRepActive), .RefillWE(RefillWE),
        .RefillWay(RefillWay), .RefillWordIdx(RefillWordIdx),
        .ValidClr(ValidClr), .TagWE(TagWE)
    );

    always #5 clk = ~clk;

    // Cache-array model: contents the tag/valid RAMs would hold, plus replacement pointers.
    bit             m_valid [S][E];
    logic [BAW-1:0] m_tag   [S][E];
    int             m_ptr   [S];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic         lv;
        logic [E-1:0] hit;
        int           set;
        logic         red;
        logic         exp_miss;
        logic         exp_stall;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [E-1:0] valid_vec(input int s);
        logic [E-1:0] v;
        for (int i = 0; i < E; i++) v[i] = m_valid[s][i];
        return v;
    endfunction

    function automatic logic [E-1:0] hit_vec(input int s, input logic [BAW-1:0] ba);
        logic [E-1:0] h;
        for (int i = 0; i < E; i++) h[i] = m_valid[s][i] && (m_tag[s][i] == ba);
        return h;
    endfunction

    function automatic int pick_victim(input int s);
        for (int i = 0; i < E; i++) if (!m_valid[s][i]) return i;
        return m_ptr[s];
    endfunction

    task automatic drive_lookup(input int s, input logic [BAW-1:0] ba, input logic lv);
        Set         = 6'(s);
        BlockAddr   = ba;
        LookupValid = lv;
        HitWay      = hit_vec(s, ba);
        ValidWays   = valid_vec(s);
    endtask

    // mode: 0 normal, 1 redirect in REQ, 2 redirect with ack, 3 redirect in a
    // beat-less cycle before beat kred, 4 redirect with last beat, 5 redirect with beat kred
    task automatic refill(input int s, input logic [BAW-1:0] ba, input bit bp, input int mode,
                          input int kred, input bit fixed_gaps, output logic [E-1:0] way_seen);
        int v, g, d;
        bit drain, red, we;
        logic [AW-1:0] exp_addr;
        v        = pick_victim(s);
        exp_addr = {ba, 4'b0000};
        way_seen = '0;
        drain    = (mode == 2);
        drive_lookup(s, ba, 1'b1);
        BranchPendingE = bp;
        @(negedge clk);
        chk("miss_flag", InstrMissF, 1);
        chk("miss_stall", InstrCacheRepActive, 1);
        chk("memreq_idle", MemReq, 0);
        next_cyc();
        if (bp) begin
            BranchPendingE = 1'b0;
            @(negedge clk);
            chk("delay_memreq", MemReq, 0);
            chk("delay_stall", InstrCacheRepActive, 1);
            next_cyc();
        end
        d = fixed_gaps ? 0 : $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            chk("req_memreq", MemReq, 1);
            chk("req_addr", MemAddr, exp_addr);
            next_cyc();
        end
        if (mode == 1) begin
            Redirect = 1'b1;
            @(negedge clk);
            chk("req_red_memreq", MemReq, 1);
            next_cyc();
            Redirect    = 1'b0;
            LookupValid = 1'b0;
            @(negedge clk);
            chk("req_red_drop", MemReq, 0);
            chk("req_red_stall", InstrCacheRepActive, 0);
            next_cyc();
            return;
        end
        MemAck   = 1'b1;
        Redirect = (mode == 2);
        @(negedge clk);
        chk("ack_memreq", MemReq, 1);
        chk("ack_addr", MemAddr, exp_addr);
        next_cyc();
        MemAck   = 1'b0;
        Redirect = 1'b0;
        if (drain) LookupValid = 1'b0;
        for (int k = 0; k < B; k++) begin
            g = fixed_gaps ? (k % 2) * 2 : $urandom_range(0, 2);
            if (mode == 3 && k == kred && g == 0) g = 1;
            for (int j = 0; j < g; j++) begin
                red      = (mode == 3 && k == kred && j == 0);
                Redirect = red;
                @(negedge clk);
                chk("gap_we", RefillWE, 0);
                chk("gap_stall", InstrCacheRepActive, 1);
                next_cyc();
                Redirect = 1'b0;
                if (red) begin
                    drain       = 1'b1;
                    LookupValid = 1'b0;
                end
            end
            red      = (mode == 5 && k == kred) || (mode == 4 && k == B - 1);
            we       = !drain && !(red && k != B - 1);
            MemValid = 1'b1;
            Redirect = red;
            @(negedge clk);
            chk("beat_we", RefillWE, we);
            chk("beat_tagwe", TagWE, we && k == B - 1);
            chk("beat_vclr", ValidClr, we && k == 0);
            chk("beat_memreq", MemReq, 0);
            if (we) begin
                chk("beat_idx", RefillWordIdx, k);
                chk("beat_way", RefillWay, 1 << v);
                if (way_seen == '0) way_seen = RefillWay;
            end
            next_cyc();
            MemValid = 1'b0;
            Redirect = 1'b0;
            if (red) LookupValid = 1'b0;
            if (red && k != B - 1) drain = 1'b1;
            if (we && k == 0) m_valid[s][v] = 1'b0;
            if (we && k == B - 1) begin
                m_valid[s][v] = 1'b1;
                m_tag[s][v]   = ba;
                if (v == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % E;
            end
        end
        drive_lookup(s, ba, LookupValid);
        @(negedge clk);
        chk("post_stall", InstrCacheRepActive, 0);
        if (LookupValid) chk("post_rehit", InstrMissF, 0);
        next_cyc();
        LookupValid = 1'b0;
    endtask

    task automatic hit_lookup(input int s, input logic [BAW-1:0] ba);
        drive_lookup(s, ba, 1'b1);
        Redirect = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        chk("hit_miss", InstrMissF, 0);
        chk("hit_stall", InstrCacheRepActive, 0);
        chk("hit_memreq", MemReq, 0);
        next_cyc();
        LookupValid = 1'b0;
        Redirect    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [E-1:0]   w;
        logic [BAW-1:0] ba;
        int             s, r, mode, kred;

        reset = 1'b1; Set = '0; BlockAddr = '0; LookupValid = 1'b0; HitWay = '0;
        ValidWays = '0; BranchPendingE = 1'b0; Redirect = 1'b0; MemAck = 1'b0; MemValid = 1'b0;
        for (int i = 0; i < S; i++) begin
            m_ptr[i] = 0;
            for (int j = 0; j < E; j++) begin
                m_valid[i][j] = 1'b0;
                m_tag[i][j]   = '0;
            end
        end

        tbl[0] = '{1'b1, 4'b0010,  5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'b0001, 63, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'b0000,  7, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'b0000, 12, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 4'b1000,  0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 4'b0000, 33, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'b0000,  1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 4'b0100, 62, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_memreq", MemReq, 0);
        chk("rst_we", RefillWE, 0);
        chk("rst_tagwe", TagWE, 0);
        chk("rst_vclr", ValidClr, 0);
        chk("rst_stall", InstrCacheRepActive, 0);
        chk("rst_idx", RefillWordIdx, 0);
        chk("rst_way", RefillWay, 0);
        next_cyc();

        for (int i = 0; i < 8; i++) begin
            Set         = 6'(tbl[i].set);
            LookupValid = tbl[i].lv;
            HitWay      = tbl[i].hit;
            ValidWays   = 4'b1111;
            Redirect    = tbl[i].red;
            @(negedge clk);
            chk("tbl_miss", InstrMissF, tbl[i].exp_miss);
            chk("tbl_stall", InstrCacheRepActive, tbl[i].exp_stall);
            chk("tbl_active", ActiveArray, 64'd1 << tbl[i].set);
            chk("tbl_memreq", MemReq, 0);
            next_cyc();
        end
        LookupValid = 1'b0; HitWay = '0; Redirect = 1'b0;

        // Cold miss to set 5 with beat gaps of 0 and 2 cycles.
        refill(5, 28'h00ABC05, 1'b0, 0, 0, 1'b1, w);
        chk("cold_way", w, 4'b0001);

        // Full sets 9 and 10: round-robin from way 0.
        for (int i = 0; i < E; i++) begin
            m_valid[9][i]  = 1'b1; m_tag[9][i]  = 28'hF000000 + 28'(i);
            m_valid[10][i] = 1'b1; m_tag[10][i] = 28'hE000000 + 28'(i);
        end
        refill(9, 28'h0100009, 1'b0, 0, 0, 1'b0, w);
        chk("rr_way0", w, 4'b0001);
        refill(9, 28'h0200009, 1'b1, 0, 0, 1'b0, w);
        chk("rr_way1", w, 4'b0010);
        refill(9, 28'h0300009, 1'b0, 0, 0, 1'b0, w);
        chk("rr_way2", w, 4'b0100);
        refill(10, 28'h010000A, 1'b0, 0, 0, 1'b0, w);
        chk("rr_other_set", w, 4'b0001);

        // Branch pending then redirect during the delay cycle.
        drive_lookup(20, 28'h0550014, 1'b1);
        BranchPendingE = 1'b1;
        @(negedge clk);
        chk("bp_stall", InstrCacheRepActive, 1);
        chk("bp_memreq", MemReq, 0);
        next_cyc();
        BranchPendingE = 1'b0;
        Redirect       = 1'b1;
        @(negedge clk);
        chk("bp_delay_stall", InstrCacheRepActive, 1);
        chk("bp_delay_memreq", MemReq, 0);
        next_cyc();
        Redirect    = 1'b0;
        LookupValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_idle_stall", InstrCacheRepActive, 0);
            chk("bp_idle_memreq", MemReq, 0);
            next_cyc();
        end

        // Redirect before beat 2: way 3 is drained, then refilled by the next miss.
        refill(9, 28'h0400009, 1'b0, 3, 2, 1'b0, w);
        chk("drain_way", w, 4'b1000);
        refill(9, 28'h0500009, 1'b0, 0, 0, 1'b0, w);
        chk("drain_refill_way", w, 4'b1000);
        refill(9, 28'h0600009, 1'b0, 0, 0, 1'b0, w);
        chk("drain_next_way", w, 4'b0001);

        refill(11, 28'h010000B, 1'b0, 1, 0, 1'b0, w);
        refill(11, 28'h020000B, 1'b1, 2, 0, 1'b0, w);
        refill(11, 28'h030000B, 1'b0, 4, 0, 1'b0, w);
        chk("late_red_way", w, 4'b0001);

        // Asynchronous reset in the middle of a beat cycle.
        drive_lookup(12, 28'h077000C, 1'b1);
        next_cyc();
        MemAck = 1'b1;
        next_cyc();
        MemAck      = 1'b0;
        LookupValid = 1'b0;
        MemValid    = 1'b1;
        #2;
        chk("pre_rst_we", RefillWE, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_we", RefillWE, 0);
        chk("async_rst_tagwe", TagWE, 0);
        chk("async_rst_memreq", MemReq, 0);
        chk("async_rst_stall", InstrCacheRepActive, 0);
        MemValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < S; i++) m_ptr[i] = 0;
        @(negedge clk);
        chk("post_rst_idx", RefillWordIdx, 0);
        chk("post_rst_memreq", MemReq, 0);
        next_cyc();
        refill(12, 28'h077000C, 1'b0, 0, 0, 1'b0, w);
        chk("post_rst_way", w, 4'b0001);

        // Random fetch stream over a few sets and a small tag pool.
        for (int it = 0; it < 200; it++) begin
            s  = $urandom_range(0, 3);
            ba = 28'(($urandom_range(0, 5) << 6) | s);
            if (|hit_vec(s, ba)) begin
                hit_lookup(s, ba);
            end else begin
                r    = $urandom_range(0, 9);
                mode = (r < 5) ? 0 : r - 4;
                kred = (mode == 5) ? $urandom_range(0, B - 2) : $urandom_range(0, B - 1);
                refill(s, ba, 1'($urandom_range(0, 1)), mode, kred, 1'b0, w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
